mcb_port_bram: RTL

//  Stand-in for one Spartan-6 MCB user port (p0 command/write/read FIFOs), backed by on-chip block RAM.

---
 rtl/mcb_pkg.sv | 28 ++
 rtl/mcb_port_bram_if.sv | 48 ++++
 rtl/mcb_port_bram_sync_fifo.sv | 64 ++++++
 rtl/mcb_port_bram.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mcb_pkg.sv
// Shared definitions for the BRAM-backed MCB port stand-in:
// command encodings, engine state encoding and instruction classifiers.
package mcb_pkg;

  localparam logic [2:0] MCB_INSTR_WR    = 3'b000;
  localparam logic [2:0] MCB_INSTR_RD    = 3'b001;
  localparam logic [2:0] MCB_INSTR_WR_AP = 3'b010;
  localparam logic [2:0] MCB_INSTR_RD_AP = 3'b011;
  localparam logic [2:0] MCB_INSTR_REF   = 3'b100;
  localparam logic [2:0] MCB_INSTR_PRE   = 3'b101;

  typedef enum logic [2:0] {
    S_CALIB,
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RDDRAIN
  } state_t;

  function automatic logic instr_is_wr(input logic [2:0] i);
    return (i == MCB_INSTR_WR) || (i == MCB_INSTR_WR_AP);
  endfunction

  function automatic logic instr_is_rd(input logic [2:0] i);
    return (i == MCB_INSTR_RD) || (i == MCB_INSTR_RD_AP);
  endfunction

endpackage

// File: rtl/mcb_port_bram_if.sv
// p0 user-port bundle: command, write-data and read-data FIFO
// signals plus calib_done; slave = port side, master = initiator.
interface mcb_port_bram_if;

  logic        calib_done;
  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic        p0_cmd_full;
  logic        p0_wr_en;
  logic [31:0] p0_wr_data;
  logic [3:0]  p0_wr_mask;
  logic        p0_wr_full;
  logic        p0_wr_empty;
  logic [6:0]  p0_wr_count;
  logic        p0_wr_error;
  logic        p0_rd_en;
  logic [31:0] p0_rd_data;
  logic        p0_rd_empty;
  logic [6:0]  p0_rd_count;
  logic        p0_rd_error;

  modport slave (
    input  p0_cmd_en, p0_cmd_instr, p0_cmd_bl,
    input  p0_cmd_byte_addr,
    input  p0_wr_en, p0_wr_data, p0_wr_mask,
    input  p0_rd_en,
    output calib_done, p0_cmd_full,
    output p0_wr_full, p0_wr_empty,
    output p0_wr_count, p0_wr_error,
    output p0_rd_data, p0_rd_empty,
    output p0_rd_count, p0_rd_error
  );

  modport master (
    output p0_cmd_en, p0_cmd_instr, p0_cmd_bl,
    output p0_cmd_byte_addr,
    output p0_wr_en, p0_wr_data, p0_wr_mask,
    output p0_rd_en,
    input  calib_done, p0_cmd_full,
    input  p0_wr_full, p0_wr_empty,
    input  p0_wr_count, p0_wr_error,
    input  p0_rd_data, p0_rd_empty,
    input  p0_rd_count, p0_rd_error
  );

endinterface

// File: rtl/mcb_port_bram_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power
// of two so the pointers wrap naturally. Empty head reads as zero.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rptr_q];

  // Pushes while full and pops while empty are dropped.
  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + AW'(1) : rptr_q;
    cnt_d   = cnt_q;
    if (push_ok && !pop_ok)
      cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop_ok)
      cnt_d = cnt_q - CW'(1);
  end

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wptr_q] <= din;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mcb_port_bram.sv
// MCB p0 user-port stand-in backed by block RAM: command, write and
// read FIFOs in front of a burst engine that walks a 32-bit BRAM.
module mcb_port_bram
  import mcb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_DEPTH   = 64,
  parameter int CMD_DEPTH    = 4,
  parameter int CALIB_CYCLES = 16
) (
  input logic             clk,
  input logic             reset,
  mcb_port_bram_if.slave  mcb
);

  localparam int CNT_W = $clog2(CALIB_CYCLES + 1);
  localparam int DCW   = $clog2(DATA_DEPTH + 1);
  localparam int CCW   = $clog2(CMD_DEPTH + 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cal_q, cal_d;
  logic [5:0]            beat_q, beat_d;
  logic [5:0]            bl_q, bl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_err_q, rd_err_d;

  logic                  calib_done;
  logic                  cmd_push, cmd_pop;
  logic                  cmd_full, cmd_empty;
  logic [38:0]           cmd_head;
  logic [CCW-1:0]        unused_cmd_count;
  logic [2:0]            head_instr;
  logic [5:0]            head_bl;
  logic [29:0]           head_addr;
  logic                  unused_addr_bits;

  logic                  wr_pop, wr_full, wr_empty;
  logic [35:0]           wr_head;
  logic [DCW-1:0]        wr_cnt;

  logic                  rd_full_unused, rd_empty;
  logic [DCW-1:0]        rd_cnt;

  logic [DCW-1:0]        need, room;
  logic                  bram_we;
  logic [31:0]           bram [2**ADDR_WIDTH];
  logic [31:0]           bram_rd_q;

  assign calib_done = (state_q != S_CALIB);
  assign cmd_push   = mcb.p0_cmd_en && calib_done;
  assign head_instr = cmd_head[38:36];
  assign head_bl    = cmd_head[35:30];
  assign head_addr  = cmd_head[29:0];
  assign unused_addr_bits =
    ^{head_addr[29:ADDR_WIDTH+2], head_addr[1:0]};
  assign need = DCW'(head_bl) + DCW'(1);
  assign room = DCW'(DATA_DEPTH) - rd_cnt;

  sync_fifo #(.WIDTH(39), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_push),
    .din   ({mcb.p0_cmd_instr, mcb.p0_cmd_bl,
             mcb.p0_cmd_byte_addr}),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (unused_cmd_count)
  );

  sync_fifo #(.WIDTH(36), .DEPTH(DATA_DEPTH)) u_wr (
    .clk   (clk),
    .reset (reset),
    .push  (mcb.p0_wr_en),
    .din   ({mcb.p0_wr_mask, mcb.p0_wr_data}),
    .pop   (wr_pop),
    .dout  (wr_head),
    .full  (wr_full),
    .empty (wr_empty),
    .count (wr_cnt)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH)) u_rd (
    .clk   (clk),
    .reset (reset),
    .push  (rd_pend_q),
    .din   (bram_rd_q),
    .pop   (mcb.p0_rd_en),
    .dout  (mcb.p0_rd_data),
    .full  (rd_full_unused),
    .empty (rd_empty),
    .count (rd_cnt)
  );

  assign mcb.calib_done  = calib_done;
  assign mcb.p0_cmd_full = cmd_full || !calib_done;
  assign mcb.p0_wr_full  = wr_full;
  assign mcb.p0_wr_empty = wr_empty;
  assign mcb.p0_wr_count = wr_cnt;
  assign mcb.p0_wr_error = wr_err_q;
  assign mcb.p0_rd_empty = rd_empty;
  assign mcb.p0_rd_count = rd_cnt;
  assign mcb.p0_rd_error = rd_err_q;

  // Burst engine: a command is popped only once its data (write)
  // or its FIFO room (read) is guaranteed, so bursts never stall.
  always_comb begin
    state_d   = state_q;
    cal_d     = cal_q;
    beat_d    = beat_q;
    bl_d      = bl_q;
    addr_d    = addr_q;
    rd_pend_d = 1'b0;
    cmd_pop   = 1'b0;
    wr_pop    = 1'b0;
    bram_we   = 1'b0;
    wr_err_d  = wr_err_q || (mcb.p0_wr_en && wr_full);
    rd_err_d  = rd_err_q || (mcb.p0_rd_en && rd_empty);
    unique case (state_q)
      S_CALIB: begin
        cal_d = cal_q + CNT_W'(1);
        if (cal_q == CNT_W'(CALIB_CYCLES - 1))
          state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!cmd_empty) begin
          if (instr_is_wr(head_instr)) begin
            if (wr_cnt >= need) begin
              cmd_pop = 1'b1;
              state_d = S_WRITE;
            end
          end else if (instr_is_rd(head_instr)) begin
            if (room >= need) begin
              cmd_pop = 1'b1;
              state_d = S_READ;
            end
          end else begin
            cmd_pop = 1'b1;
          end
          if (cmd_pop) begin
            beat_d = '0;
            bl_d   = head_bl;
            addr_d = head_addr[ADDR_WIDTH+1:2];
          end
        end
      end
      S_WRITE: begin
        wr_pop  = 1'b1;
        bram_we = 1'b1;
        addr_d  = addr_q + ADDR_WIDTH'(1);
        beat_d  = beat_q + 6'd1;
        if (beat_q == bl_q)
          state_d = S_IDLE;
      end
      S_READ: begin
        rd_pend_d = 1'b1;
        addr_d    = addr_q + ADDR_WIDTH'(1);
        beat_d    = beat_q + 6'd1;
        if (beat_q == bl_q)
          state_d = S_RDDRAIN;
      end
      S_RDDRAIN: state_d = S_IDLE;
      default:   state_d = S_CALIB;
    endcase
  end

  // Engine and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CALIB;
      cal_q     <= '0;
      beat_q    <= '0;
      bl_q      <= '0;
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cal_q     <= cal_d;
      beat_q    <= beat_d;
      bl_q      <= bl_d;
      addr_q    <= addr_d;
      rd_pend_q <= rd_pend_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
    end
  end

  // Block RAM: byte-masked write, registered read; never reset.
  always_ff @(posedge clk) begin
    if (bram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_head[32+b])
          bram[addr_q][8*b +: 8] <= wr_head[8*b +: 8];
      end
    end
    bram_rd_q <= bram[addr_q];
  end

endmodule
